// File: rtl/frame_pkg.sv
// Shared command-frame definitions for the TX packer and the RX frame decoder:
// field widths, command codes, field offsets and buffer occupancy encoding.
package frame_pkg;

  localparam int unsigned CMD_W   = 32'd8;
  localparam int unsigned ADDR_W  = 32'd16;
  localparam int unsigned DATA_W  = 32'd32;
  localparam int unsigned FRAME_W = CMD_W + ADDR_W + DATA_W;

  localparam logic [CMD_W-1:0] CMD_WR  = 8'h01;
  localparam logic [CMD_W-1:0] CMD_RD  = 8'h02;
  localparam logic [CMD_W-1:0] CMD_RES = 8'h04;

  localparam int unsigned DATA_LSB = 32'd0;
  localparam int unsigned ADDR_LSB = DATA_LSB + DATA_W;
  localparam int unsigned CMD_LSB  = ADDR_LSB + ADDR_W;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  // Read frames never carry payload, so the data field is forced to zero.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic              wr,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    logic [FRAME_W-1:0] frame;
    frame = '0;
    frame[CMD_LSB +: CMD_W]   = wr ? CMD_WR : CMD_RD;
    frame[ADDR_LSB +: ADDR_W] = addr;
    frame[DATA_LSB +: DATA_W] = wr ? data : {DATA_W{1'b0}};
    return frame;
  endfunction

endpackage

// File: rtl/frame_buf2.sv
// Two-entry in-order register buffer with head/tail pointers and an
// EMPTY/ONE/TWO occupancy FSM; pushes into TWO and pops from EMPTY are ignored.
module frame_buf2
  import frame_pkg::*;
#(
  parameter int unsigned W = 32'd56
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head_data,
  output occ_state_e   occ
);

  occ_state_e   state_r;
  occ_state_e   state_s;
  logic [W-1:0] entry_r [2];
  logic         head_r;
  logic         tail_r;
  logic         push_ok_s;
  logic         pop_ok_s;

  assign push_ok_s = push && (state_r != OCC_TWO);
  assign pop_ok_s  = pop && (state_r != OCC_EMPTY);
  assign head_data = entry_r[head_r];
  assign occ       = state_r;

  // State register, pointers and storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= OCC_EMPTY;
      head_r     <= 1'b0;
      tail_r     <= 1'b0;
      entry_r[0] <= '0;
      entry_r[1] <= '0;
    end else begin
      state_r <= state_s;
      if (push_ok_s) begin
        entry_r[tail_r] <= push_data;
        tail_r          <= ~tail_r;
      end
      if (pop_ok_s) begin
        head_r <= ~head_r;
      end
    end
  end

  // Occupancy next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      OCC_EMPTY: begin
        if (push_ok_s) state_s = OCC_ONE;
        else           state_s = OCC_EMPTY;
      end
      OCC_ONE: begin
        if (push_ok_s && !pop_ok_s)      state_s = OCC_TWO;
        else if (pop_ok_s && !push_ok_s) state_s = OCC_EMPTY;
        else                             state_s = OCC_ONE;
      end
      OCC_TWO: begin
        if (pop_ok_s) state_s = OCC_ONE;
        else          state_s = OCC_TWO;
      end
      default: state_s = OCC_EMPTY;
    endcase
  end

endmodule

// File: rtl/cmd_frame_packer.sv
// Command-frame packer: formats APB requests into 56-bit frames, buffers two,
// and writes them to the TX FIFO. Optional drain counter under FRAME_CNT_EN.
module cmd_frame_packer #(
  parameter int unsigned CMD_W  = 32'd8,
  parameter int unsigned ADDR_W = 32'd16,
  parameter int unsigned DATA_W = 32'd32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_vld,
  input  logic                            req_wr,
  input  logic [ADDR_W-1:0]               req_addr,
  input  logic [DATA_W-1:0]               req_data,
  output logic                            req_rdy,
  input  logic                            fifo_full,
  output logic                            fifo_wen,
  output logic [CMD_W+ADDR_W+DATA_W-1:0]  fifo_wdata,
  output logic                            busy
`ifdef FRAME_CNT_EN
  ,
  input  logic                            cnt_clr,
  output logic [15:0]                     frame_cnt
`endif
);

  import frame_pkg::*;

  occ_state_e                    occ_s;
  logic                          accept_s;
  logic [CMD_W+ADDR_W+DATA_W-1:0] frame_s;

  // Ready is independent of fifo_full so no combinational path reaches req_rdy.
  assign req_rdy  = !rst && (occ_s != OCC_TWO);
  assign accept_s = req_vld && req_rdy;
  assign fifo_wen = (occ_s != OCC_EMPTY) && !fifo_full;
  assign busy     = (occ_s != OCC_EMPTY);
  assign frame_s  = build_frame(req_wr, req_addr, req_data);

  frame_buf2 #(
    .W (CMD_W + ADDR_W + DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (accept_s),
    .pop       (fifo_wen),
    .push_data (frame_s),
    .head_data (fifo_wdata),
    .occ       (occ_s)
  );

`ifdef FRAME_CNT_EN
  logic [15:0] cnt_r;

  // Drain counter; clear has priority over a coincident drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 16'h0000;
    end else if (cnt_clr) begin
      cnt_r <= 16'h0000;
    end else if (fifo_wen) begin
      cnt_r <= cnt_r + 16'h0001;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign frame_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_cmd_frame_packer.sv
// Self-checking bench for cmd_frame_packer: queue-based reference model checked
// every cycle, plus directed tests with literal expectations.
`timescale 1ns/1ps
module tb_cmd_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [31:0] req_data;
  logic        req_rdy;
  logic        fifo_full;
  logic        fifo_wen;
  logic [55:0] fifo_wdata;
  logic        busy;
  logic        cnt_clr;
`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [55:0] model_q[$];
  logic [15:0] model_cnt = 16'h0000;

  cmd_frame_packer dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_rdy    (req_rdy),
    .fifo_full  (fifo_full),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .busy       (busy)
`ifdef FRAME_CNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [55:0] exp_frame(input logic wr, input logic [15:0] a, input logic [31:0] d);
    return {(wr ? 8'h01 : 8'h02), a, (wr ? d : 32'h0)};
  endfunction

  // Reference model: a FIFO of frames in acceptance order.
  always @(posedge clk) begin
    if (rst) begin
      model_q.delete();
      model_cnt = 16'h0000;
    end else begin
      bit acc;
      bit drn;
      acc = req_vld && (model_q.size() < 2);
      drn = (model_q.size() != 0) && !fifo_full;
      if (drn) void'(model_q.pop_front());
      if (cnt_clr)  model_cnt = 16'h0000;
      else if (drn) model_cnt = model_cnt + 16'h0001;
      if (acc) model_q.push_back(exp_frame(req_wr, req_addr, req_data));
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit ew;
      ew = (model_q.size() != 0) && !fifo_full;
      check("busy", busy, model_q.size() != 0);
      check("req_rdy", req_rdy, !rst && (model_q.size() < 2));
      check("fifo_wen", fifo_wen, ew);
      if (ew) check("fifo_wdata", fifo_wdata, model_q[0]);
`ifdef FRAME_CNT_EN
      check("frame_cnt", frame_cnt, model_cnt);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one request and wait (bounded) until an edge accepts it.
  task automatic send(input logic wr, input logic [15:0] a, input logic [31:0] d);
    bit rdy_v;
    bit done;
    done     = 1'b0;
    req_vld  = 1'b1;
    req_wr   = wr;
    req_addr = a;
    req_data = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy_v = req_rdy;
      @(posedge clk);
      #1;
      done = rdy_v;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    req_vld = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] sa [20];
    logic [31:0] sd [20];
    logic [55:0] f1;
    logic [55:0] f2;

    rst = 1'b1; req_vld = 1'b1; req_wr = 1'b1; req_addr = 16'h1234;
    req_data = 32'hCAFEF00D; fifo_full = 1'b0; cnt_clr = 1'b0;

    // Reset with a request pending.
    step();
    chk_en = 1'b1;
    step();
    @(negedge clk);
    check("rst_fifo_wen", fifo_wen, 1'b0);
    check("rst_req_rdy", req_rdy, 1'b0);
    check("rst_fifo_wdata", fifo_wdata, 56'h0);
    step();
    rst = 1'b0; req_vld = 1'b0;
    @(negedge clk);
    check("post_rst_req_rdy", req_rdy, 1'b1);
    check("post_rst_busy", busy, 1'b0);
`ifdef FRAME_CNT_EN
    check("post_rst_frame_cnt", frame_cnt, 16'h0000);
`endif

    // Single write.
    step();
    send(1'b1, 16'h0010, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_fifo_wen", fifo_wen, 1'b1);
    check("wr_fifo_wdata", fifo_wdata, 56'h01_0010_DEADBEEF);
    @(negedge clk);
    check("wr_fifo_wen_once", fifo_wen, 1'b0);

    // Single read.
    step();
    send(1'b0, 16'hA5A5, 32'h12345678);
    @(negedge clk);
    check("rd_fifo_wen", fifo_wen, 1'b1);
    check("rd_fifo_wdata", fifo_wdata, 56'h02_A5A5_00000000);

    // Backpressure: three offers, two accepted.
    step();
    fifo_full = 1'b1;
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 16'h0001; req_data = 32'h11111111;
    step();
    req_wr = 1'b0; req_addr = 16'h0002; req_data = 32'h22222222;
    step();
    req_wr = 1'b1; req_addr = 16'h0003; req_data = 32'h33333333;
    @(negedge clk);
    check("bp_req_rdy", req_rdy, 1'b0);
    check("bp_fifo_wen", fifo_wen, 1'b0);
    check("bp_busy", busy, 1'b1);
    step();
    step();
    req_vld = 1'b0; fifo_full = 1'b0;
    f1 = 56'h01_0001_11111111;
    f2 = 56'h02_0002_00000000;
    @(negedge clk);
    check("bp_first_wen", fifo_wen, 1'b1);
    check("bp_first_data", fifo_wdata, f1);
    @(negedge clk);
    check("bp_second_wen", fifo_wen, 1'b1);
    check("bp_second_data", fifo_wdata, f2);
    check("bp_rdy_back", req_rdy, 1'b1);
    @(negedge clk);
    check("bp_drained", fifo_wen, 1'b0);

    // Streaming 20 back-to-back writes.
    for (int i = 0; i < 20; i++) begin
      sa[i] = 16'($urandom);
      sd[i] = $urandom;
    end
    for (int i = 0; i < 20; i++) begin
      step();
      req_vld = 1'b1; req_wr = 1'b1; req_addr = sa[i]; req_data = sd[i];
      @(negedge clk);
      check("st_req_rdy", req_rdy, 1'b1);
      if (i > 0) begin
        check("st_wen", fifo_wen, 1'b1);
        check("st_data", fifo_wdata, {8'h01, sa[i-1], sd[i-1]});
      end
    end
    step();
    req_vld = 1'b0;
    @(negedge clk);
    check("st_last_wen", fifo_wen, 1'b1);
    check("st_last_data", fifo_wdata, {8'h01, sa[19], sd[19]});
    @(negedge clk);
    check("st_end_wen", fifo_wen, 1'b0);

`ifdef FRAME_CNT_EN
    // Counter wrap and clear.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 65534; i++) begin
      req_vld = 1'b1; req_wr = 1'b1; req_addr = 16'(i); req_data = $urandom;
      step();
    end
    req_vld = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("cnt_fffe", frame_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step();
      req_vld = 1'b1; req_wr = 1'b0; req_addr = 16'(i); req_data = $urandom;
    end
    step();
    req_vld = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("cnt_wrap", frame_cnt, 16'h0001);
    step();
    req_vld = 1'b1;
    step();
    req_vld = 1'b0;
    cnt_clr = 1'b1;
    @(negedge clk);
    check("clr_with_drain_wen", fifo_wen, 1'b1);
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    check("cnt_cleared", frame_cnt, 16'h0000);
`endif

    // Randomized traffic with backpressure, drops, clears and resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (req_vld && !req_rdy && !rst) begin
        if ($urandom_range(0, 3) == 0) req_vld = 1'b0;
      end else begin
        req_vld  = ($urandom_range(0, 2) != 0);
        req_wr   = 1'($urandom);
        req_addr = 16'($urandom);
        req_data = $urandom;
      end
      rst       = ($urandom_range(0, 299) == 0);
      fifo_full = ((c / 100) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      cnt_clr   = ($urandom_range(0, 63) == 0);
    end
    step();
    req_vld = 1'b0; rst = 1'b0; fifo_full = 1'b0; cnt_clr = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_frame_packer.md
# cmd_frame_packer

Sequential command-frame packer on the APB clock domain, the transmit-side counterpart of the frame decoder. It accepts APB-slave-side write/read requests over a valid/ready handshake, builds 56-bit command frames and buffers up to two of them. It then pushes each frame into the TX async FIFO under full-flag backpressure, and the UART transmitter later drains that FIFO.

## Interface
Parameters:
- CMD_W, 8, command field width
- ADDR_W, 16, address field width
- DATA_W, 32, data field width; frame width FRAME_W = CMD_W+ADDR_W+DATA_W = 56

Ports:
- clk  in  1  APB-domain clock; one clock, all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- req_vld  in  1  request valid
- req_wr  in  1  1 = write request, 0 = read request
- req_addr  in  ADDR_W  request address
- req_data  in  DATA_W  write data; ignored for reads
- req_rdy  out  1  packer can accept a request this cycle
- fifo_full  in  1  TX FIFO full flag
- fifo_wen  out  1  TX FIFO write enable
- fifo_wdata  out  FRAME_W  frame to TX FIFO
- busy  out  1  at least one frame buffered
- cnt_clr  in  1  frame counter clear (only with FRAME_CNT_EN)
- frame_cnt  out  16  frames written to FIFO (only with FRAME_CNT_EN)

## Operation
- Frame layout, MSB first: {cmd[55:48], addr[47:32], data[31:0]}.
- Command codes: write = 8'h01, read = 8'h02. Read frames carry data = 32'h0.
- 2-entry in-order buffer. Occupancy FSM has three states:
  - EMPTY: occupancy 0.
  - ONE: occupancy 1.
  - TWO: occupancy 2.
- Accept event: req_vld && req_rdy at a rising edge. The frame is built from the request fields and written to the tail entry.
- Drain event: fifo_wen high at a rising edge. The head entry is retired.
- Transitions:
  - EMPTY → ONE on accept.
  - ONE → TWO on accept without drain.
  - ONE → EMPTY on drain without accept.
  - ONE stays ONE on simultaneous accept and drain.
  - TWO → ONE on drain.
  - Accept is impossible in TWO because req_rdy is low.
- req_rdy = !rst && state != TWO. It does not depend on fifo_full, so there is no combinational path from fifo_full to req_rdy.
- fifo_wen = state != EMPTY && !fifo_full (combinational).
- fifo_wdata = head entry, held stable while fifo_wen is low and state != EMPTY.
- busy = state != EMPTY.
- Requester rule: while req_vld && !req_rdy, the request fields must hold stable. Deasserting req_vld before acceptance drops the request, and no frame is produced.
- Order preserved: frames leave in acceptance order, no reordering and no duplication.

## Timing
- Reset (rst high at an edge):
  - State goes to EMPTY and both buffer entries are cleared.
  - fifo_wen = 0, fifo_wdata = 0, busy = 0, req_rdy = 0, frame_cnt = 0.
- req_rdy rises in the first cycle after rst drops.
- Latency: a request accepted at edge t, into an EMPTY buffer with fifo_full low, presents fifo_wen = 1 in the cycle following edge t.
- Throughput: 1 frame/cycle sustained while fifo_full is low.
- fifo_full high: fifo_wen low in that same cycle. The buffer fills to TWO, then req_rdy drops.
- fifo_full falls: fifo_wen rises in the same cycle. The head frame goes out first.
- Reset mid-operation: buffered frames are discarded, and no partial frame is written.

## Configuration
- Macro: FRAME_CNT_EN.
- Defined:
  - cnt_clr and frame_cnt ports exist.
  - A 16-bit counter increments on every drain event and wraps 16'hFFFF → 16'h0000.
  - cnt_clr clears it synchronously on the next edge; clear wins over a simultaneous increment.
  - Reset value 0.
- Undefined: cnt_clr and frame_cnt are absent, and the packer's other behaviour is unchanged.

## Structure
- Shared package frame_pkg holds:
  - CMD_W, ADDR_W, DATA_W, FRAME_W.
  - Command codes CMD_WR = 8'h01, CMD_RD = 8'h02, CMD_RES = 8'h04.
  - Field bit offsets.
  - Occupancy state encoding.
- The same package is shared with the decoder.
- One sub-module, frame_buf2: a 2-entry register buffer with head/tail pointers and occupancy FSM. The top level does frame formatting, FIFO handshake and the optional counter.

## Test plan
- Reset: with rst held, drive req_vld=1. Required: no fifo_wen and req_rdy=0. After release, req_rdy=1, busy=0, frame_cnt=0.
- Single write:
  - Stimulus: req_wr=1, addr 16'h0010, data 32'hDEADBEEF, fifo_full=0.
  - Required: one cycle later fifo_wen=1 for exactly one cycle, fifo_wdata=56'h01_0010_DEADBEEF.
- Single read:
  - Stimulus: req_wr=0, addr 16'hA5A5, data 32'h12345678.
  - Required: fifo_wdata=56'h02_A5A5_00000000.
- Backpressure:
  - Stimulus: fifo_full=1, offer three back-to-back requests.
  - Required: two accepted, then req_rdy=0 and fifo_wen=0.
  - Release fifo_full. Required: the two frames are written in order on consecutive cycles, then req_rdy=1.
- Streaming: 20 back-to-back requests with fifo_full=0. Required: 20 frames in order, no gaps after the first, req_rdy held 1.
- Counter (FRAME_CNT_EN):
  - Preload the count to 16'hFFFE and send 3 frames. Required: frame_cnt reads 16'h0001.
  - Assert cnt_clr together with a drain. Required: frame_cnt=0.
